// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 key event path between hps_io and the CPU keyboard port.
package ps2_pkg;

    typedef struct packed {
        logic       pressed;
        logic       extended;
        logic [7:0] code;
    } key_event_t;

    localparam int PS2_TOGGLE_BIT = 10;
    localparam int KEY_EVENT_W    = $bits(key_event_t);

endpackage

// File: rtl/fifo_sync.sv
// Generic single-clock show-ahead FIFO: head entry is visible on dout whenever not empty.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A pop frees the head slot in the same cycle, so a full queue can still accept a push.
    assign do_pop  = pop && !empty && !clr;
    assign do_push = push && !clr && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; stale data is hidden behind empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_key_fifo.sv
// Captures each hps_io ps2_key toggle as a {pressed,extended,code} event and queues it for the CPU.
module ps2_key_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [10:0]   ps2_key,
    input  logic          rd,
    input  logic          clr,
    output logic [9:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow
);

    logic       armed;
    logic       tog_prev;
    logic       push;
    key_event_t ev;
    key_event_t head;

    assign ev   = key_event_t'(ps2_key[KEY_EVENT_W-1:0]);
    assign push = armed && (ps2_key[PS2_TOGGLE_BIT] != tog_prev);
    assign dout = head;

    // The first edge after reset only samples the toggle level, so a stale level is not an event.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed    <= 1'b0;
            tog_prev <= 1'b0;
        end else begin
            armed    <= 1'b1;
            tog_prev <= ps2_key[PS2_TOGGLE_BIT];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (clr)
            overflow <= 1'b0;
        else if (push && full && !rd)
            overflow <= 1'b1;
    end

    fifo_sync #(
        .WIDTH (KEY_EVENT_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .clr   (clr),
        .push  (push),
        .pop   (rd),
        .din   (ev),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Randomized and directed checks of ps2_key_fifo against a queue-based event model.
module tb_ps2_key_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic [10:0]   ps2_key = '0;
    logic          rd      = 1'b0;
    logic          clr     = 1'b0;
    logic [9:0]    dout;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [9:0] q[$];
    logic       m_armed = 1'b0;
    logic       m_tog   = 1'b0;
    logic       m_ovf   = 1'b0;

    ps2_key_fifo #(.DEPTH(DEPTH)) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_key  (ps2_key),
        .rd       (rd),
        .clr      (clr),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ":count"}, 32'(count), 32'(q.size()));
        chk({tag, ":empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ":full"},  32'(full),  32'(q.size() == DEPTH));
        chk({tag, ":ovf"},   32'(overflow), 32'(m_ovf));
        if (q.size() != 0) chk({tag, ":dout"}, 32'(dout), 32'(q[0]));
    endtask

    // One clock: apply inputs, advance the model at the edge, compare 1ns later.
    task automatic step(input logic tgl, input logic [9:0] data, input logic r, input logic c,
                        input string tag);
        logic push;
        logic pop_ok;
        ps2_key = {tgl ? ~ps2_key[10] : ps2_key[10], data};
        rd      = r;
        clr     = c;
        @(posedge clk_sys);
        if (!m_armed) begin
            m_armed = 1'b1;
            m_tog   = ps2_key[10];
        end else begin
            push  = (ps2_key[10] != m_tog);
            m_tog = ps2_key[10];
            if (c) begin
                q.delete();
                m_ovf = 1'b0;
            end else begin
                pop_ok = r && (q.size() != 0);
                if (pop_ok) void'(q.pop_front());
                if (push) begin
                    if (q.size() < DEPTH) q.push_back(ps2_key[9:0]);
                    else m_ovf = 1'b1;
                end
            end
        end
        #1;
        chk_model(tag);
        rd  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 10'($urandom), 1'b0, 1'b0, tag);
    endtask

    // Asserts reset between edges, checks the async clear, releases before the next edge.
    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #1;
        q.delete();
        m_armed = 1'b0;
        m_ovf   = 1'b0;
        chk({tag, ":rst_count"}, 32'(count), 0);
        chk({tag, ":rst_empty"}, 32'(empty), 1);
        chk({tag, ":rst_full"},  32'(full), 0);
        chk({tag, ":rst_ovf"},   32'(overflow), 0);
        chk({tag, ":rst_dout"},  32'(dout), 0);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        // 1: reset released with toggle bit high must not create an event
        ps2_key = 11'h400;
        #2;
        async_reset("t1");
        for (int i = 0; i < 10; i++) idle("t1_idle");
        chk("t1_empty", 32'(empty), 1);

        // 2: single 'A' press
        step(1'b1, 10'h21C, 1'b0, 1'b0, "t2_push");
        chk("t2_dout", 32'(dout), 32'h21C);
        step(1'b0, 10'h0, 1'b1, 1'b0, "t2_pop");
        chk("t2_empty", 32'(empty), 1);

        // 3: fill, overflow on the 17th, then drain in order
        for (int i = 1; i <= 16; i++) step(1'b1, 10'(i), 1'b0, 1'b0, "t3_fill");
        step(1'b1, 10'h3FF, 1'b0, 1'b0, "t3_over");
        chk("t3_full", 32'(full), 1);
        chk("t3_ovf", 32'(overflow), 1);
        for (int i = 1; i <= 16; i++) begin
            chk("t3_order", 32'(dout), 32'(i));
            step(1'b0, 10'h0, 1'b1, 1'b0, "t3_drain");
        end

        // 4: full queue, simultaneous push and pop
        step(1'b0, 10'h0, 1'b0, 1'b1, "t4_clr");
        for (int i = 0; i < 16; i++) step(1'b1, 10'h100 + 10'(i), 1'b0, 1'b0, "t4_fill");
        step(1'b1, 10'h2AA, 1'b1, 1'b0, "t4_both");
        chk("t4_count", 32'(count), 16);
        chk("t4_ovf", 32'(overflow), 0);
        chk("t4_head", 32'(dout), 32'h101);
        for (int i = 0; i < 16; i++) step(1'b0, 10'h0, 1'b1, 1'b0, "t4_drain");

        // 5: pointer wrap with push/pop pairs
        for (int i = 0; i < 3; i++) step(1'b1, 10'h040 + 10'(i), 1'b0, 1'b0, "t5_fill");
        for (int i = 0; i < 20; i++) step(1'b1, 10'h080 + 10'(i), 1'b1, 1'b0, "t5_pair");
        chk("t5_count", 32'(count), 3);
        for (int i = 0; i < 3; i++) step(1'b0, 10'h0, 1'b1, 1'b0, "t5_drain");

        // 6: async reset mid-burst, then clr racing a toggle
        for (int i = 0; i < 5; i++) step(1'b1, 10'h150 + 10'(i), 1'b0, 1'b0, "t6_fill");
        chk("t6_count5", 32'(count), 5);
        async_reset("t6");
        idle("t6_arm");
        step(1'b1, 10'h1F0, 1'b0, 1'b0, "t6_after_rst");
        chk("t6_requeue", 32'(dout), 32'h1F0);
        step(1'b1, 10'h111, 1'b0, 1'b0, "t6_push2");
        step(1'b1, 10'h222, 1'b0, 1'b1, "t6_clr");
        chk("t6_clr_count", 32'(count), 0);
        step(1'b1, 10'h333, 1'b0, 1'b0, "t6_after_clr");
        chk("t6_after_clr_dout", 32'(dout), 32'h333);

        // randomized traffic, biased toward pushes so the full/overflow corners recur
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset("rnd");
                idle("rnd_arm");
            end else begin
                step(($urandom_range(0, 99) < 55), 10'($urandom),
                     ($urandom_range(0, 99) < 45), ($urandom_range(0, 199) == 0), "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
